// File: rtl/hsv_track_pkg.sv
// Shared types for the HSV colour tracker: pixel/threshold bundles,
// bounding box and FSM state encoding.
package hsv_track_pkg;

    localparam int H_RANGE  = 360;
    localparam int S_MAX    = 100;
    localparam int V_MAX    = 100;
    localparam int BBOX_X_W = 9;
    localparam int BBOX_Y_W = 8;

    typedef struct packed {
        logic [9:0] h;
        logic [6:0] s;
        logic [6:0] v;
    } hsv_t;

    typedef struct packed {
        logic [9:0] h_lo;
        logic [9:0] h_hi;
        logic [6:0] s_min;
        logic [6:0] v_min;
    } hsv_thr_t;

    typedef struct packed {
        logic [BBOX_X_W-1:0] x0;
        logic [BBOX_X_W-1:0] x1;
        logic [BBOX_Y_W-1:0] y0;
        logic [BBOX_Y_W-1:0] y1;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PUBLISH
    } track_state_e;

endpackage

// File: rtl/hsv_window_cmp.sv
// Combinational HSV window test; the hue window wraps through 0
// when h_lo > h_hi.
module hsv_window_cmp
    import hsv_track_pkg::*;
(
    input  hsv_t     pix,
    input  hsv_thr_t thr,
    output logic     match
);

    logic h_legal;
    logic above_lo;
    logic below_hi;
    logic h_ok;

    always_comb begin
        h_legal  = pix.h < 10'(H_RANGE);
        above_lo = pix.h >= thr.h_lo;
        below_hi = pix.h <= thr.h_hi;
        if (thr.h_lo <= thr.h_hi) begin
            h_ok = h_legal && above_lo && below_hi;
        end else begin
            h_ok = h_legal && (above_lo || below_hi);
        end
        match = h_ok && (pix.s >= thr.s_min) && (pix.v >= thr.v_min);
    end

endmodule

// File: rtl/hsv_color_tracker.sv
// Per-pixel HSV colour mask plus per-frame bbox/count statistics.
// Define TRACK_HYST_EN for multi-frame hysteresis on obj_found.
module hsv_color_tracker
    import hsv_track_pkg::*;
#(
`ifdef TRACK_HYST_EN
    parameter int FOUND_FRAMES = 3,
`endif
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int X_W        = BBOX_X_W,
    parameter int Y_W        = BBOX_Y_W,
    parameter int CNT_W      = 17,
    parameter int MIN_PIXELS = 64
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pix_valid,
    input  logic [X_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_in,
    input  logic [9:0]       h_in,
    input  logic [6:0]       s_in,
    input  logic [6:0]       v_in,
    input  logic [9:0]       h_lo,
    input  logic [9:0]       h_hi,
    input  logic [6:0]       s_min,
    input  logic [6:0]       v_min,
    output logic             mask_out,
    output logic             mask_valid,
    output logic [X_W-1:0]   bbox_x0,
    output logic [X_W-1:0]   bbox_x1,
    output logic [Y_W-1:0]   bbox_y0,
    output logic [Y_W-1:0]   bbox_y1,
    output logic [CNT_W-1:0] match_cnt,
    output logic             obj_found,
    output logic             result_valid
);

    hsv_t         pix;
    hsv_thr_t     live_thr;
    hsv_thr_t     shd_thr;
    logic         live_match;
    logic         shd_match;
    track_state_e state;
    track_state_e next_state;
    logic         start_acc;
    logic         acc_en;
    logic         do_publish;
    logic         in_area;
    logic         take;
    bbox_t        acc;
    logic [CNT_W-1:0] acc_cnt;
    logic         hit;

    assign pix      = '{h: h_in, s: s_in, v: v_in};
    assign live_thr = '{h_lo: h_lo, h_hi: h_hi, s_min: s_min, v_min: v_min};

    hsv_window_cmp u_live_cmp (
        .pix   (pix),
        .thr   (live_thr),
        .match (live_match)
    );

    hsv_window_cmp u_shd_cmp (
        .pix   (pix),
        .thr   (shd_thr),
        .match (shd_match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_valid <= 1'b0;
            mask_out   <= 1'b0;
        end else begin
            mask_valid <= pix_valid;
            mask_out   <= pix_valid && live_match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (frame_start) next_state = ACTIVE;
            ACTIVE:  if (frame_end) next_state = PUBLISH;
            PUBLISH: next_state = frame_start ? ACTIVE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // frame_end beats a coincident frame_start while a frame is open
    always_comb begin
        start_acc  = frame_start && !(state == ACTIVE && frame_end);
        acc_en     = (state == ACTIVE) && !start_acc;
        do_publish = (state == PUBLISH);
    end

    assign in_area = (x_in < X_W'(IMG_W)) && (y_in < Y_W'(IMG_H));
    assign take    = acc_en && pix_valid && in_area && shd_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_thr <= '0;
            acc     <= '0;
            acc_cnt <= '0;
        end else if (start_acc) begin
            shd_thr <= live_thr;
            acc.x0  <= '1;
            acc.y0  <= '1;
            acc.x1  <= '0;
            acc.y1  <= '0;
            acc_cnt <= '0;
        end else if (take) begin
            if (x_in < acc.x0) acc.x0 <= x_in;
            if (x_in > acc.x1) acc.x1 <= x_in;
            if (y_in < acc.y0) acc.y0 <= y_in;
            if (y_in > acc.y1) acc.y1 <= y_in;
            if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
        end
    end

    assign hit = acc_cnt >= CNT_W'(MIN_PIXELS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bbox_x0      <= '0;
            bbox_x1      <= '0;
            bbox_y0      <= '0;
            bbox_y1      <= '0;
            match_cnt    <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= do_publish;
            if (do_publish) begin
                match_cnt <= acc_cnt;
                if (acc_cnt == '0) begin
                    bbox_x0 <= '0;
                    bbox_x1 <= '0;
                    bbox_y0 <= '0;
                    bbox_y1 <= '0;
                end else begin
                    bbox_x0 <= acc.x0;
                    bbox_x1 <= acc.x1;
                    bbox_y0 <= acc.y0;
                    bbox_y1 <= acc.y1;
                end
            end
        end
    end

`ifdef TRACK_HYST_EN
    localparam int HW = $clog2(FOUND_FRAMES + 1);

    logic [HW-1:0] hit_run;
    logic [HW-1:0] miss_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_run   <= '0;
            miss_run  <= '0;
            obj_found <= 1'b0;
        end else if (do_publish) begin
            if (hit) begin
                miss_run <= '0;
                if (hit_run != HW'(FOUND_FRAMES)) hit_run <= hit_run + 1'b1;
                if (hit_run >= HW'(FOUND_FRAMES - 1)) obj_found <= 1'b1;
            end else begin
                hit_run <= '0;
                if (miss_run != HW'(FOUND_FRAMES)) miss_run <= miss_run + 1'b1;
                if (miss_run >= HW'(FOUND_FRAMES - 1)) obj_found <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obj_found <= 1'b0;
        end else if (do_publish) begin
            obj_found <= hit;
        end
    end
`endif

endmodule

// File: tb/tb_hsv_color_tracker.sv
// Scoreboard bench for hsv_color_tracker: mask and frame-result queues
// filled at drive time, drained when the DUT signals valid.
module tb_hsv_color_tracker;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       frame_end;
    logic       pix_valid;
    logic [8:0] x_in;
    logic [7:0] y_in;
    logic [9:0] h_in;
    logic [6:0] s_in;
    logic [6:0] v_in;
    logic [9:0] h_lo;
    logic [9:0] h_hi;
    logic [6:0] s_min;
    logic [6:0] v_min;
    logic       mask_out;
    logic       mask_valid;
    logic [8:0] bbox_x0;
    logic [8:0] bbox_x1;
    logic [7:0] bbox_y0;
    logic [7:0] bbox_y1;
    logic [16:0] match_cnt;
    logic       obj_found;
    logic       result_valid;

    hsv_color_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .pix_valid    (pix_valid),
        .x_in         (x_in),
        .y_in         (y_in),
        .h_in         (h_in),
        .s_in         (s_in),
        .v_in         (v_in),
        .h_lo         (h_lo),
        .h_hi         (h_hi),
        .s_min        (s_min),
        .v_min        (v_min),
        .mask_out     (mask_out),
        .mask_valid   (mask_valid),
        .bbox_x0      (bbox_x0),
        .bbox_x1      (bbox_x1),
        .bbox_y0      (bbox_y0),
        .bbox_y1      (bbox_y1),
        .match_cnt    (match_cnt),
        .obj_found    (obj_found),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x0;
        int x1;
        int y0;
        int y1;
        int cnt;
        int obj;
    } res_t;

    res_t rq[$];
    int   mq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    // reference model state
    int ms = 0;
    int sh_lo, sh_hi, sh_s, sh_v;
    int ax0, ax1, ay0, ay1, acnt;
    int hit_run = 0;
    int miss_run = 0;
    int m_obj = 0;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_match(int h, int s, int v,
                                     int lo, int hi, int smin, int vmin);
        int hue;
        if (h >= 360) hue = 0;
        else if (lo <= hi) hue = (h >= lo && h <= hi) ? 1 : 0;
        else hue = (h > hi && h < lo) ? 0 : 1;
        return (hue == 1 && s >= smin && v >= vmin) ? 1 : 0;
    endfunction

    function automatic res_t make_result();
        res_t r;
        int hit;
        r.due = cyc + 2;
        r.cnt = acnt;
        if (acnt == 0) begin
            r.x0 = 0; r.x1 = 0; r.y0 = 0; r.y1 = 0;
        end else begin
            r.x0 = ax0; r.x1 = ax1; r.y0 = ay0; r.y1 = ay1;
        end
        hit = (acnt >= 64) ? 1 : 0;
`ifdef TRACK_HYST_EN
        if (hit == 1) begin
            miss_run = 0;
            hit_run++;
            if (hit_run >= 3) m_obj = 1;
        end else begin
            hit_run = 0;
            miss_run++;
            if (miss_run >= 3) m_obj = 0;
        end
`else
        m_obj = hit;
`endif
        r.obj = m_obj;
        return r;
    endfunction

    task automatic drive(int fs, int fe, int pv,
                         int x, int y, int h, int s, int v);
        int start;
        @(negedge clk);
        frame_start = fs[0];
        frame_end   = fe[0];
        pix_valid   = pv[0];
        x_in = 9'(x);
        y_in = 8'(y);
        h_in = 10'(h);
        s_in = 7'(s);
        v_in = 7'(v);
        if (pv == 1)
            mq.push_back(ref_match(h, s, v, int'(h_lo), int'(h_hi),
                                   int'(s_min), int'(v_min)));
        start = (fs == 1 && !(ms == 1 && fe == 1)) ? 1 : 0;
        if (ms == 1 && start == 0 && pv == 1 && x < 320 && y < 240 &&
            ref_match(h, s, v, sh_lo, sh_hi, sh_s, sh_v) == 1) begin
            if (x < ax0) ax0 = x;
            if (x > ax1) ax1 = x;
            if (y < ay0) ay0 = y;
            if (y > ay1) ay1 = y;
            acnt++;
        end
        if (ms == 1 && fe == 1) begin
            rq.push_back(make_result());
            ms = 2;
        end else if (start == 1) begin
            sh_lo = int'(h_lo); sh_hi = int'(h_hi);
            sh_s  = int'(s_min); sh_v = int'(v_min);
            ax0 = 511; ay0 = 255; ax1 = 0; ay1 = 0; acnt = 0;
            ms = 1;
        end else if (ms == 2) begin
            ms = 0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_thr(int lo, int hi, int smin, int vmin);
        idle(1);
        h_lo  = 10'(lo);
        h_hi  = 10'(hi);
        s_min = 7'(smin);
        v_min = 7'(vmin);
    endtask

    task automatic begin_frame();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic end_frame();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic block(int x0, int y0, int w, int ht, int h, int end_last);
        for (int yy = 0; yy < ht; yy++)
            for (int xx = 0; xx < w; xx++)
                drive(0, (end_last == 1 && yy == ht - 1 && xx == w - 1) ? 1 : 0,
                      1, x0 + xx, y0 + yy, h, 50, 50);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_mask_valid"}, 32'(mask_valid), 0);
        check({tag, "_mask_out"}, 32'(mask_out), 0);
        check({tag, "_result_valid"}, 32'(result_valid), 0);
        check({tag, "_match_cnt"}, 32'(match_cnt), 0);
        check({tag, "_x0"}, 32'(bbox_x0), 0);
        check({tag, "_x1"}, 32'(bbox_x1), 0);
        check({tag, "_y0"}, 32'(bbox_y0), 0);
        check({tag, "_y1"}, 32'(bbox_y1), 0);
        check({tag, "_obj"}, 32'(obj_found), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ms = 0; hit_run = 0; miss_run = 0; m_obj = 0;
        #1;
        check_zero("rst_active");
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        res_t r;
        #1;
        if (!reset) begin
            if (mask_valid) begin
                if (mq.size() == 0) check("mask_extra", 1, 0);
                else check("mask", 32'(mask_out), mq.pop_front());
            end
            if (result_valid) begin
                if (rq.size() == 0) begin
                    check("result_extra", 1, 0);
                end else begin
                    r = rq.pop_front();
                    check("res_latency", cyc, r.due);
                    check("res_cnt", 32'(match_cnt), r.cnt);
                    check("res_x0", 32'(bbox_x0), r.x0);
                    check("res_x1", 32'(bbox_x1), r.x1);
                    check("res_y0", 32'(bbox_y0), r.y0);
                    check("res_y1", 32'(bbox_y1), r.y1);
                    check("res_obj", 32'(obj_found), r.obj);
                end
            end
        end
    end

    int hues[8] = '{350, 5, 180, 360, 340, 20, 21, 339};
    int pat[6]  = '{1, 1, 0, 1, 1, 1};

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        x_in = '0; y_in = '0; h_in = '0; s_in = '0; v_in = '0;
        h_lo = 10'd100; h_hi = 10'd140; s_min = 7'd30; v_min = 7'd30;
        repeat (3) @(negedge clk);
        check_zero("rst_init");
        reset = 1'b0;

        // linear window and boundaries
        set_thr(100, 140, 30, 30);
        drive(0, 0, 1, 0, 0, 120, 50, 50);
        drive(0, 0, 1, 0, 0, 141, 50, 50);
        drive(0, 0, 1, 0, 0, 100, 30, 30);
        drive(0, 0, 1, 0, 0, 140, 50, 50);
        drive(0, 0, 1, 0, 0, 99, 50, 50);
        drive(0, 0, 1, 0, 0, 120, 29, 50);
        drive(0, 0, 1, 0, 0, 120, 50, 29);
        idle(2);

        // wrapped window
        set_thr(340, 20, 30, 30);
        foreach (hues[i]) drive(0, 0, 1, 0, 0, hues[i], 50, 50);
        idle(2);

        // 10x10 block; live window moved mid-frame, stats use shadow
        set_thr(100, 140, 30, 30);
        begin_frame();
        drive(0, 0, 1, 300, 100, 200, 50, 50);
        set_thr(0, 10, 30, 30);
        block(10, 5, 10, 10, 120, 1);
        idle(4);

        // empty frame
        set_thr(100, 140, 30, 30);
        begin_frame();
        block(0, 0, 4, 1, 200, 0);
        end_frame();
        idle(4);

        // restart mid-frame discards earlier pixels
        begin_frame();
        drive(0, 0, 1, 50, 50, 120, 50, 50);
        begin_frame();
        block(0, 0, 7, 10, 120, 0);
        end_frame();
        idle(4);

        // start+end together while active: end wins; end in idle ignored
        begin_frame();
        block(3, 3, 8, 8, 120, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        end_frame();
        idle(4);

        // start in publish cycle opens the next frame
        begin_frame();
        block(20, 20, 2, 2, 120, 0);
        end_frame();
        begin_frame();
        block(30, 30, 3, 3, 120, 0);
        end_frame();
        idle(4);

        // hit/miss sequence at the MIN_PIXELS boundary
        foreach (pat[i]) begin
            begin_frame();
            block(40, 40, 8, 7, 120, 0);
            block(40, 47, (pat[i] == 1) ? 8 : 7, 1, 120, 0);
            end_frame();
            idle(3);
        end

        // reset during an open frame
        begin_frame();
        block(60, 60, 3, 3, 120, 0);
        idle(1);
        do_reset();
        idle(2);

        for (int i = 0; i < 20 && (mq.size() != 0 || rq.size() != 0); i++)
            @(negedge clk);
        check("mask_drain", mq.size(), 0);
        check("result_drain", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
